// File: rtl/logic_proc_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_proc_param_if
//  Description : Control/data bundle of the bit-serial logic processor.
//                Optional Zero/Parity flags present when LOGIC_PROC_FLAGS_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic_proc_param_if #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
);
    localparam int CW = $clog2(WIDTH / DIGIT) + 1;

    logic             LoadA;
    logic             LoadB;
    logic             Execute;
    logic [WIDTH-1:0] Din;
    logic [2:0]       F;
    logic [1:0]       R;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Busy;
    logic             Done;
    logic [CW-1:0]    Count;
`ifdef LOGIC_PROC_FLAGS_EN
    logic             Zero;
    logic             Parity;

    modport master (
        output LoadA, LoadB, Execute, Din, F, R,
        input  Aval, Bval, Busy, Done, Count, Zero, Parity
    );
    modport slave (
        input  LoadA, LoadB, Execute, Din, F, R,
        output Aval, Bval, Busy, Done, Count, Zero, Parity
    );
`else
    modport master (
        output LoadA, LoadB, Execute, Din, F, R,
        input  Aval, Bval, Busy, Done, Count
    );
    modport slave (
        input  LoadA, LoadB, Execute, Din, F, R,
        output Aval, Bval, Busy, Done, Count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/logic_proc_param.sv
`default_nettype none
// ============================================================================
//  Module      : logic_proc_param
//  Description : Parametrised bit-serial logic processor. Holds A/B registers,
//                applies one of eight bitwise functions DIGIT bits per clock
//                and routes the result back into A and/or B.
//                Optional feature macro: LOGIC_PROC_FLAGS_EN (Zero/Parity).
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_proc_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    logic_proc_param_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    count_q;
    logic             done_q;
    logic [2:0]       f_lat;
    logic [1:0]       r_lat;

    logic             start;
    logic             shift_en;
    logic             last_shift;
    logic [DIGIT-1:0] a_lo;
    logic [DIGIT-1:0] b_lo;
    logic [DIGIT-1:0] digit_res;
    logic [DIGIT-1:0] a_in;
    logic [DIGIT-1:0] b_in;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        shift_en   = 1'b0;
        last_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Execute) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (count_q == LAST_COUNT) begin
                    last_shift = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (!bus.Execute) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-digit function and routing of the low digits of A and B
    always_comb begin
        a_lo = a_q[DIGIT-1:0];
        b_lo = b_q[DIGIT-1:0];
        case (f_lat)
            3'b000:  digit_res = a_lo & b_lo;
            3'b001:  digit_res = a_lo | b_lo;
            3'b010:  digit_res = a_lo ^ b_lo;
            3'b011:  digit_res = {DIGIT{1'b1}};
            3'b100:  digit_res = ~(a_lo & b_lo);
            3'b101:  digit_res = ~(a_lo | b_lo);
            3'b110:  digit_res = ~(a_lo ^ b_lo);
            default: digit_res = {DIGIT{1'b0}};
        endcase
        // Unrouted registers rotate their own low digit back in
        case (r_lat)
            2'b01:   begin a_in = a_lo;      b_in = digit_res; end
            2'b10:   begin a_in = digit_res; b_in = b_lo;      end
            2'b11:   begin a_in = b_lo;      b_in = a_lo;      end
            default: begin a_in = a_lo;      b_in = b_lo;      end
        endcase
        a_next = (a_q >> DIGIT) | (WIDTH'(a_in) << (WIDTH - DIGIT));
        b_next = (b_q >> DIGIT) | (WIDTH'(b_in) << (WIDTH - DIGIT));
    end

    // Datapath registers: loads in IDLE, latch F/R on start, shift in SHIFT
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            f_lat   <= 3'b000;
            r_lat   <= 2'b00;
        end else begin
            done_q <= last_shift;
            if (start) begin
                // Execute takes priority over a load on the same edge
                count_q <= '0;
                f_lat   <= bus.F;
                r_lat   <= bus.R;
            end else if (shift_en) begin
                a_q     <= a_next;
                b_q     <= b_next;
                count_q <= count_q + CW'(1);
            end else if (state_q == IDLE) begin
                if (bus.LoadA) a_q <= bus.Din;
                if (bus.LoadB) b_q <= bus.Din;
            end
        end
    end

`ifdef LOGIC_PROC_FLAGS_EN
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             zero_q;
    logic             parity_q;

    // Full result assembled digit by digit, independent of routing
    always_comb begin
        res_next = (res_sr >> DIGIT) | (WIDTH'(digit_res) << (WIDTH - DIGIT));
    end

    // Result collector and flags captured on the completing edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            res_sr   <= '0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            if (shift_en) res_sr <= res_next;
            if (last_shift) begin
                zero_q   <= ~|res_next;
                parity_q <= ^res_next;
            end
        end
    end

    assign bus.Zero   = zero_q;
    assign bus.Parity = parity_q;
`endif

    assign bus.Aval  = a_q;
    assign bus.Bval  = b_q;
    assign bus.Busy  = (state_q == SHIFT);
    assign bus.Done  = done_q;
    assign bus.Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_proc_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_proc_param
//  Description : Self-checking bench for logic_proc_param (8x1 and 16x4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_proc_param;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;

    logic_proc_param_if #(.WIDTH(8),  .DIGIT(1)) b8 ();
    logic_proc_param_if #(.WIDTH(16), .DIGIT(4)) b16 ();

    logic_proc_param #(.WIDTH(8),  .DIGIT(1)) dut8  (.Clk(Clk), .Reset(Reset), .bus(b8));
    logic_proc_param #(.WIDTH(16), .DIGIT(4)) dut16 (.Clk(Clk), .Reset(Reset), .bus(b16));

    typedef struct {
        logic [7:0] a_in;
        logic [7:0] b_in;
        logic [2:0] f;
        logic [1:0] r;
        int         hold;
        logic [7:0] a_exp;
        logic [7:0] b_exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        b8.LoadA = 1'b1; b8.Din = a;
        @(negedge Clk);
        b8.LoadA = 1'b0; b8.LoadB = 1'b1; b8.Din = b;
        @(negedge Clk);
        b8.LoadB = 1'b0;
    endtask

    // Starts an op at a negedge, holds Execute for 'hold' cycles, observes
    task automatic exec8(input logic [2:0] f, input logic [1:0] r, input int hold,
                         output int busy_n, output int done_n, output int done_at);
        busy_n = 0; done_n = 0; done_at = 0;
        b8.F = f; b8.R = r; b8.Execute = 1'b1;
        for (int i = 1; i <= hold + 12; i++) begin
            @(negedge Clk);
            if (i >= hold) b8.Execute = 1'b0;
            if (b8.Busy) busy_n++;
            if (b8.Done) begin
                done_n++;
                if (done_at == 0) done_at = i;
            end
        end
    endtask

    initial begin
        int bn, dn, da;
        b8.LoadA = 0; b8.LoadB = 0; b8.Execute = 0; b8.Din = '0; b8.F = '0; b8.R = '0;
        b16.LoadA = 0; b16.LoadB = 0; b16.Execute = 0; b16.Din = '0; b16.F = '0; b16.R = '0;

        //            a_in   b_in   f       r     hold a_exp  b_exp
        vecs[0] = '{8'h33, 8'h55, 3'b010, 2'b10, 11, 8'h66, 8'h55};
        vecs[1] = '{8'h66, 8'h55, 3'b110, 2'b01,  1, 8'h66, 8'hCC};
        vecs[2] = '{8'h66, 8'hCC, 3'b110, 2'b11, 20, 8'hCC, 8'h66};
        vecs[3] = '{8'hF0, 8'h0F, 3'b000, 2'b10,  2, 8'h00, 8'h0F};
        vecs[4] = '{8'hA5, 8'h3C, 3'b001, 2'b01,  3, 8'hA5, 8'hBD};
        vecs[5] = '{8'h12, 8'h34, 3'b011, 2'b10,  1, 8'hFF, 8'h34};
        vecs[6] = '{8'h12, 8'h34, 3'b100, 2'b10,  5, 8'hEF, 8'h34};
        vecs[7] = '{8'h12, 8'h34, 3'b101, 2'b01,  1, 8'h12, 8'hC9};
        vecs[8] = '{8'h12, 8'h34, 3'b111, 2'b10,  9, 8'h00, 8'h34};
        vecs[9] = '{8'h81, 8'h7E, 3'b010, 2'b00,  1, 8'h81, 8'h7E};

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_aval", {24'd0, b8.Aval}, 32'h0);
        chk("rst_busy", {31'd0, b8.Busy}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_bval",  {24'd0, b8.Bval}, 32'h0);
        chk("rst_done",  {31'd0, b8.Done}, 32'h0);
        chk("rst_count", {28'd0, b8.Count}, 32'h0);

        // Table-driven operations on the 8x1 instance
        for (int v = 0; v < 10; v++) begin
            load8(vecs[v].a_in, vecs[v].b_in);
            chk($sformatf("v%0d_loadA", v), {24'd0, b8.Aval}, {24'd0, vecs[v].a_in});
            chk($sformatf("v%0d_loadB", v), {24'd0, b8.Bval}, {24'd0, vecs[v].b_in});
            exec8(vecs[v].f, vecs[v].r, vecs[v].hold, bn, dn, da);
            chk($sformatf("v%0d_A", v), {24'd0, b8.Aval}, {24'd0, vecs[v].a_exp});
            chk($sformatf("v%0d_B", v), {24'd0, b8.Bval}, {24'd0, vecs[v].b_exp});
            chk($sformatf("v%0d_busy_cycles", v), bn, 32'd8);
            chk($sformatf("v%0d_done_pulses", v), dn, 32'd1);
            chk($sformatf("v%0d_done_cycle", v), da, 32'd9);
            chk($sformatf("v%0d_count", v), {28'd0, b8.Count}, 32'd8);
        end

`ifdef LOGIC_PROC_FLAGS_EN
        load8(8'h12, 8'h34);
        exec8(3'b111, 2'b00, 1, bn, dn, da);
        chk("flg_zero_f111", {31'd0, b8.Zero}, 32'd1);
        chk("flg_par_f111",  {31'd0, b8.Parity}, 32'd0);
        chk("flg_A_f111", {24'd0, b8.Aval}, 32'h12);
        chk("flg_B_f111", {24'd0, b8.Bval}, 32'h34);
        exec8(3'b011, 2'b00, 1, bn, dn, da);
        chk("flg_zero_f011", {31'd0, b8.Zero}, 32'd0);
        chk("flg_par_f011",  {31'd0, b8.Parity}, 32'd0);
        exec8(3'b010, 2'b00, 1, bn, dn, da);
        chk("flg_zero_xor", {31'd0, b8.Zero}, 32'd0);
        chk("flg_par_xor",  {31'd0, b8.Parity}, 32'd1);
`endif

        // Load, F and R changes during SHIFT have no effect
        load8(8'h0F, 8'h35);
        b8.F = 3'b000; b8.R = 2'b10; b8.Execute = 1'b1;
        @(negedge Clk);
        b8.Execute = 1'b0;
        repeat (2) @(negedge Clk);
        b8.LoadA = 1'b1; b8.Din = 8'hAA; b8.F = 3'b001; b8.R = 2'b01;
        repeat (2) @(negedge Clk);
        b8.LoadA = 1'b0;
        repeat (10) @(negedge Clk);
        chk("midload_A", {24'd0, b8.Aval}, 32'h05);
        chk("midload_B", {24'd0, b8.Bval}, 32'h35);

        // Execute wins over a load sampled on the same edge
        b8.LoadA = 1'b1; b8.Din = 8'hFF; b8.F = 3'b010; b8.R = 2'b00; b8.Execute = 1'b1;
        @(negedge Clk);
        b8.LoadA = 1'b0; b8.Execute = 1'b0;
        chk("exwin_busy", {31'd0, b8.Busy}, 32'd1);
        repeat (12) @(negedge Clk);
        chk("exwin_A", {24'd0, b8.Aval}, 32'h05);
        chk("exwin_B", {24'd0, b8.Bval}, 32'h35);

        // Reset in the middle of an operation
        load8(8'h33, 8'h55);
        b8.F = 3'b010; b8.R = 2'b10; b8.Execute = 1'b1;
        @(negedge Clk);
        b8.Execute = 1'b0;
        repeat (3) @(negedge Clk);
        chk("mid_count3", {28'd0, b8.Count}, 32'd3);
        Reset = 1'b1;
        #1;
        chk("midrst_A",    {24'd0, b8.Aval}, 32'h0);
        chk("midrst_B",    {24'd0, b8.Bval}, 32'h0);
        chk("midrst_busy", {31'd0, b8.Busy}, 32'd0);
        chk("midrst_cnt",  {28'd0, b8.Count}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (b8.Done) dn++;
        end
        chk("midrst_no_done", dn, 32'd0);
        chk("midrst_idle_A", {24'd0, b8.Aval}, 32'h0);

        // 16x4 instance: NOR routed to A, four shift cycles
        b16.LoadA = 1'b1; b16.Din = 16'hF0F0;
        @(negedge Clk);
        b16.LoadA = 1'b0; b16.LoadB = 1'b1; b16.Din = 16'h0FF0;
        @(negedge Clk);
        b16.LoadB = 1'b0;
        b16.F = 3'b101; b16.R = 2'b10; b16.Execute = 1'b1;
        bn = 0; dn = 0; da = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            b16.Execute = 1'b0;
            if (b16.Busy) bn++;
            if (b16.Done) begin
                dn++;
                if (da == 0) da = i;
            end
            if (i == 4) chk("w16_A_at_last_shift_pending", {31'd0, b16.Busy}, 32'd1);
            if (i == 5) chk("w16_A_after_4th", {16'd0, b16.Aval}, 32'h000F);
        end
        chk("w16_busy_cycles", bn, 32'd4);
        chk("w16_done_pulses", dn, 32'd1);
        chk("w16_done_cycle",  da, 32'd5);
        chk("w16_A", {16'd0, b16.Aval}, 32'h000F);
        chk("w16_B", {16'd0, b16.Bval}, 32'h0FF0);
        chk("w16_count", {29'd0, b16.Count}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
